// File: rtl/midi_byte_receiver.sv
// midi_byte_receiver: 8N1 MIDI serial receiver delivering one-cycle byte pulses with status/framing flags
module midi_byte_receiver #(
  parameter int CLKS_PER_BIT = 384
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       midi_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_status,
  output logic       framing_err,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n;
  logic sync1, sync2, valid_n, ferr_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      state       <= BRK;
      cnt         <= '0;
      idx         <= '0;
      sh          <= '0;
      rx_data     <= '0;
      rx_status   <= 1'b0;
      rx_valid    <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      sync1       <= midi_in;
      sync2       <= sync1;
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      sh          <= sh_n;
      rx_valid    <= valid_n;
      framing_err <= ferr_n;
      if (valid_n) begin
        rx_data   <= sh;
        rx_status <= sh[7];
      end
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    sh_n    = sh;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        state_n = sync2 ? IDLE : START;
      end
      START: if (cnt == HALF_M1) begin
        cnt_n   = '0;
        idx_n   = '0;
        state_n = sync2 ? IDLE : DATA;
      end
      DATA: if (cnt == FULL_M1) begin
        cnt_n   = '0;
        sh_n    = {sync2, sh[7:1]};
        idx_n   = idx + 1'b1;
        state_n = (idx == 3'd7) ? STOP : DATA;
      end
      STOP: if (cnt == FULL_M1) begin
        cnt_n   = '0;
        valid_n = sync2;
        ferr_n  = !sync2;
        state_n = sync2 ? IDLE : BRK;
      end
      BRK: begin
        cnt_n = '0;
        state_n = sync2 ? IDLE : BRK;
      end
      default: state_n = BRK;
    endcase
  end
  assign busy = state != IDLE;
endmodule

// File: tb/tb_midi_byte_receiver.sv
// tb_midi_byte_receiver: directed table-driven bench for midi_byte_receiver
module tb_midi_byte_receiver;
  localparam int C = 100;
  localparam int H = C / 2;
  logic clk = 1'b0, rst = 1'b1, midi_in = 1'b1;
  logic [7:0] rx_data;
  logic rx_valid, rx_status, framing_err, busy;
  int cyc = 0, checks = 0, errors = 0, nf = 0, nboth = 0, f_cyc = 0;
  logic [8:0] vdq[$];
  int vcq[$];
  typedef struct {
    logic [7:0] b;
    int len;
    logic [7:0] exp_d;
    logic exp_s;
  } vec_t;
  vec_t v[5];
  midi_byte_receiver #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .midi_in(midi_in), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_status(rx_status), .framing_err(framing_err), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rx_valid) begin
      vdq.push_back({rx_status, rx_data});
      vcq.push_back(cyc);
    end
    if (framing_err) begin
      nf++;
      f_cyc = cyc;
    end
    if (rx_valid && framing_err) nboth++;
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input int len, input logic stop, output int t0);
    logic [9:0] f;
    f  = {stop, b, 1'b0};
    t0 = cyc + 1;
    for (int i = 0; i < 10; i++) begin
      midi_in = f[i];
      tick(len);
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int t0, t1, n0, f0;
    logic [9:0] fa;
    v[0] = '{8'h90, C, 8'h90, 1'b1};
    v[1] = '{8'h00, C, 8'h00, 1'b0};
    v[2] = '{8'hFF, C, 8'hFF, 1'b1};
    v[3] = '{8'hC3, 103, 8'hC3, 1'b1};
    v[4] = '{8'hC3, 97, 8'hC3, 1'b1};
    tick(3);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_valid", rx_valid, 0);
    chk("rst_status", rx_status, 0);
    chk("rst_ferr", framing_err, 0);
    chk("rst_busy", busy, 1);
    rst = 1'b0;
    tick(5);
    chk("armed_idle", busy, 0);
    for (int i = 0; i < 5; i++) begin
      n0 = vdq.size();
      f0 = nf;
      send(v[i].b, v[i].len, 1'b1, t0);
      tick(20);
      chk("vec_valid_cnt", vdq.size() - n0, 1);
      chk("vec_ferr_cnt", nf - f0, 0);
      if (vdq.size() > n0) begin
        chk("vec_data", vdq[n0][7:0], v[i].exp_d);
        chk("vec_status", vdq[n0][8], v[i].exp_s);
        if (v[i].len == C) chk("vec_valid_time", vcq[n0], t0 + 2 + H + 9 * C);
      end
      chk("vec_hold", rx_data, v[i].exp_d);
      chk("vec_idle", busy, 0);
    end
    n0 = vdq.size();
    send(8'h3C, C, 1'b1, t0);
    send(8'h7F, C, 1'b1, t1);
    tick(20);
    chk("b2b_cnt", vdq.size() - n0, 2);
    if (vdq.size() >= n0 + 2) begin
      chk("b2b_d0", vdq[n0], {1'b0, 8'h3C});
      chk("b2b_d1", vdq[n0+1], {1'b0, 8'h7F});
      chk("b2b_gap", vcq[n0+1] - vcq[n0], 10 * C);
    end
    n0 = vdq.size();
    f0 = nf;
    midi_in = 1'b0;
    t0 = cyc + 1;
    tick(C / 4);
    midi_in = 1'b1;
    chk("glitch_busy_mid", busy, 1);
    while (cyc < t0 + H + 1) tick(1);
    chk("glitch_busy_hi", busy, 1);
    tick(1);
    chk("glitch_busy_lo", busy, 0);
    tick(2 * C);
    chk("glitch_no_valid", vdq.size() - n0, 0);
    chk("glitch_no_ferr", nf - f0, 0);
    n0 = vdq.size();
    f0 = nf;
    send(8'h55, C, 1'b0, t0);
    tick(20 * C);
    chk("ferr_cnt", nf - f0, 1);
    chk("ferr_time", f_cyc, t0 + 2 + H + 9 * C);
    chk("ferr_no_valid", vdq.size() - n0, 0);
    chk("ferr_data_kept", rx_data, 8'h7F);
    chk("ferr_break_busy", busy, 1);
    midi_in = 1'b1;
    tick(30);
    chk("ferr_recovered", busy, 0);
    send(8'hF8, C, 1'b1, t0);
    tick(20);
    chk("rt_cnt", vdq.size() - n0, 1);
    if (vdq.size() > n0) chk("rt_data", vdq[n0], {1'b1, 8'hF8});
    n0 = vdq.size();
    f0 = nf;
    fa = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 5; i++) begin
      midi_in = fa[i];
      tick(C);
    end
    midi_in = fa[5];
    tick(H);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_data", rx_data, 8'h00);
    chk("mid_rst_valid", rx_valid, 0);
    chk("mid_rst_status", rx_status, 0);
    chk("mid_rst_ferr", framing_err, 0);
    chk("mid_rst_busy", busy, 1);
    rst = 1'b0;
    midi_in = 1'b1;
    tick(30);
    chk("mid_rst_quiet_v", vdq.size() - n0, 0);
    chk("mid_rst_quiet_f", nf - f0, 0);
    send(8'h12, C, 1'b1, t0);
    tick(20);
    chk("after_rst_cnt", vdq.size() - n0, 1);
    if (vdq.size() > n0) chk("after_rst_data", vdq[n0], {1'b0, 8'h12});
    chk("valid_ferr_excl", nboth, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/midi_byte_receiver.md
# midi_byte_receiver

Serial-to-parallel receiver for one MIDI input line. It recovers 8-bit bytes from the 31.25 kbaud, idle-high, 8N1 MIDI stream and presents each byte as a single-cycle pulse with status and framing flags. One instance sits behind each of the four MIDI input pins. It is the byte-level counterpart of the bit-level output merge path, and it lets downstream logic merge and route whole MIDI messages instead of ANDing raw lines.

## Interface
Parameters:
- CLKS_PER_BIT, 384: clk cycles per MIDI bit (12 MHz / 31250). Must be even and ≥ 16.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- midi_in  input  1  raw asynchronous MIDI line; idle = 1.
- rx_data  output  8  last received byte, LSB first on the wire; holds its value between bytes.
- rx_valid  output  1  one-cycle pulse: rx_data/rx_status are new and good.
- rx_status  output  1  rx_data[7] of the byte just received (MIDI status byte); valid with rx_valid.
- framing_err  output  1  one-cycle pulse: stop bit sampled low; byte discarded.
- busy  output  1  high whenever state ≠ IDLE.

## Operation
- Input sync: midi_in passes through 2 flip-flops (sync1 → sync2); sync2 is the only sampled copy. Both reset to 1.
- Bit counter cnt: width ceil(log2(CLKS_PER_BIT)). Bit index idx: 3 bits. Shift register sh: 8 bits.
- States:
  - IDLE: if sync2 == 0 → START, with cnt = 0.
  - START: cnt increments each cycle. When cnt == CLKS_PER_BIT/2 − 1, sample sync2:
    - 0 → DATA, cnt = 0, idx = 0.
    - 1 (glitch/false start) → IDLE, no output.
  - DATA: cnt increments. When cnt == CLKS_PER_BIT − 1, shift sh = {sync2, sh[7:1]} and set cnt = 0. If idx == 7 → STOP, else idx + 1.
  - STOP: when cnt == CLKS_PER_BIT − 1, sample sync2:
    - 1 → register rx_data = sh, rx_status = sh[7], pulse rx_valid; go to IDLE.
    - 0 → pulse framing_err, leave rx_data unchanged; go to BREAK.
  - BREAK: wait until sync2 == 1, then go to IDLE. No start detection while in BREAK.
- Arming: after reset, the FSM enters BREAK, so a line held low at reset is never taken as a start bit.
- rx_valid and framing_err are never high in the same cycle. Each pulses for exactly one cycle per byte.
- Reset values (state after any cycle with rst = 1):
  - state = BREAK, cnt = 0, idx = 0, sh = 0
  - rx_data = 8'h00, rx_status = 0, rx_valid = 0, framing_err = 0, busy = 1 (BREAK counts as ≠ IDLE).
- Reset mid-byte: the partial byte is dropped with no rx_valid or framing_err. Reception restarts only after the line is seen high.
- No running-status or message parsing here. Every byte, including real-time (F8–FF), is delivered individually.

## Timing
- Let T0 be the first clk edge at which midi_in is sampled 0 by sync1.
  - IDLE sees sync2 = 0 at edge T0+1 and enters START at T0+2.
  - Start-bit sample at edge T0+1+CLKS_PER_BIT/2.
  - Data bit k (k = 0..7) sampled at T0+1+CLKS_PER_BIT/2+(k+1)·CLKS_PER_BIT.
  - Stop-bit sample at T0+1+CLKS_PER_BIT/2+9·CLKS_PER_BIT.
  - rx_valid or framing_err is high in the cycle following that edge.
- Back-to-back bytes: FSM is in IDLE from the stop-bit midpoint onward. A start edge CLKS_PER_BIT/2 later (zero idle gap) is accepted.
- Baud tolerance: sampling at bit centres tolerates ±4 % rate mismatch over 10 bits.
- Throughput: one byte per 10·CLKS_PER_BIT cycles maximum; no back-pressure.

## Test plan
- Reset with line high, then a clean byte 0x90 → after ≥1 idle cycle, exactly one rx_valid with rx_data = 0x90, rx_status = 1. rx_valid falls exactly at the cycle computed from T0.
- Bytes 0x3C, 0x7F sent back-to-back with zero gap → two rx_valid pulses, 10·CLKS_PER_BIT cycles apart, data 0x3C then 0x7F, rx_status = 0 for both.
- Low glitch of CLKS_PER_BIT/4 cycles on an idle line → no rx_valid and no framing_err; busy returns low after CLKS_PER_BIT/2 + 2 cycles.
- Byte 0x55 with the stop bit forced low, line then held low 20·CLKS_PER_BIT cycles, then high, then 0xF8 → one framing_err pulse, rx_data stays at its prior value, no start detected during the low hold, then rx_valid with 0xF8.
- rst asserted for 1 cycle midway through data bit 4 of 0xA5, line returned high, then 0x12 sent → no output for 0xA5; rx_valid with 0x12. All outputs show their reset values in the cycle after rst.
- Bit timing stretched +3 % and −3 % for 0xC3 → rx_data = 0xC3 in both cases.
